// File: rtl/comparator_lt_signed64_if.sv
// comparator_lt_signed64_if: operand/result bundle for the registered signed compare unit
// COMPARATOR_UNSIGNED_EN adds the unsigned less-than result lu.
interface comparator_lt_signed64_if #(parameter int WIDTH = 64);
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic [WIDTH-1:0] s;
    logic             c_o;
    logic             eq;
    logic             ls;
`ifdef COMPARATOR_UNSIGNED_EN
    logic             lu;
`endif
    modport master (
        output in_valid, a, b,
        input  out_valid, s, c_o, eq, ls
`ifdef COMPARATOR_UNSIGNED_EN
        , input lu
`endif
    );
    modport slave (
        input  in_valid, a, b,
        output out_valid, s, c_o, eq, ls
`ifdef COMPARATOR_UNSIGNED_EN
        , output lu
`endif
    );
endinterface

// File: rtl/comparator_lt_signed64.sv
// comparator_lt_signed64: registered A-B subtractor with equality and signed less-than flags
// COMPARATOR_UNSIGNED_EN adds a registered unsigned less-than flag lu = ~c_o.
module comparator_lt_signed64 #(
    parameter int WIDTH = 64
) (
    input logic                        clk,
    input logic                        rst_n,
    comparator_lt_signed64_if.slave    bus
);
    logic [WIDTH:0]   diff;
    logic             eq_n;
    logic             ls_n;
    logic             valid_d, valid_q;
    logic [WIDTH-1:0] s_d, s_q;
    logic             c_o_d, c_o_q;
    logic             eq_d, eq_q;
    logic             ls_d, ls_q;
`ifdef COMPARATOR_UNSIGNED_EN
    logic             lu_d, lu_q;
`endif

    // a + ~b + 1; with differing signs the negative operand is smaller regardless of overflow
    always_comb begin
        diff    = {1'b0, bus.a} + {1'b0, ~bus.b} + {{WIDTH{1'b0}}, 1'b1};
        eq_n    = ~|diff[WIDTH-1:0];
        ls_n    = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) ? bus.a[WIDTH-1] : diff[WIDTH-1];
        valid_d = bus.in_valid;
        s_d     = bus.in_valid ? diff[WIDTH-1:0] : s_q;
        c_o_d   = bus.in_valid ? diff[WIDTH] : c_o_q;
        eq_d    = bus.in_valid ? eq_n : eq_q;
        ls_d    = bus.in_valid ? ls_n : ls_q;
`ifdef COMPARATOR_UNSIGNED_EN
        lu_d    = bus.in_valid ? ~diff[WIDTH] : lu_q;
`endif
    end

    // result registers, cleared asynchronously so in-flight results are dropped on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            s_q     <= '0;
            c_o_q   <= 1'b0;
            eq_q    <= 1'b0;
            ls_q    <= 1'b0;
`ifdef COMPARATOR_UNSIGNED_EN
            lu_q    <= 1'b0;
`endif
        end else begin
            valid_q <= valid_d;
            s_q     <= s_d;
            c_o_q   <= c_o_d;
            eq_q    <= eq_d;
            ls_q    <= ls_d;
`ifdef COMPARATOR_UNSIGNED_EN
            lu_q    <= lu_d;
`endif
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.s         = s_q;
    assign bus.c_o       = c_o_q;
    assign bus.eq        = eq_q;
    assign bus.ls        = ls_q;
`ifdef COMPARATOR_UNSIGNED_EN
    assign bus.lu        = lu_q;
`endif
endmodule

// File: tb/tb_comparator_lt_signed64.sv
// tb_comparator_lt_signed64: scoreboard bench for the registered signed compare unit
module tb_comparator_lt_signed64;
    localparam int W = 64;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int passed = 0;
    int total = 0;
    comparator_lt_signed64_if #(.WIDTH(W)) bus ();
    comparator_lt_signed64 #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    logic lu_obs;
`ifdef COMPARATOR_UNSIGNED_EN
    assign lu_obs = bus.lu;
`else
    assign lu_obs = 1'b0;
`endif
    // observed vector: {out_valid, s, c_o, eq, ls, lu}
    logic [68:0] obs;
    assign obs = {bus.out_valid, bus.s, bus.c_o, bus.eq, bus.ls, lu_obs};

    logic [68:0] q[$];

    function automatic logic [68:0] model(input logic [63:0] a, input logic [63:0] b);
        logic lu;
        lu = 1'b0;
`ifdef COMPARATOR_UNSIGNED_EN
        lu = a < b;
`endif
        return {1'b1, a - b, a >= b, a == b, $signed(a) < $signed(b), lu};
    endfunction

    task automatic drive(input logic v, input logic [63:0] a, input logic [63:0] b, input logic [68:0] e);
        bus.in_valid = v;
        bus.a = a;
        bus.b = b;
        if (v) q.push_back(e);
    endtask

    task automatic test_reset();
        logic [68:0] e;
        drive(1'b0, '0, '0, '0);
        #1 rst_n = 1'b0;
        #1;
        e = '0;
        total++;
        if (obs !== e) $display("FAIL reset got=%h exp=%h", obs, e);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [63:0] ta[6];
        logic [63:0] tb_[6];
        logic [68:0] te[6];
        logic [68:0] e;
        logic ulu[6];
        ulu = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        ta[0] = 64'd5;                  tb_[0] = 64'd7;
        te[0] = {1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b1, 1'b0};
        ta[1] = 64'hFFFF_FFFF_FFFF_FFFF; tb_[1] = 64'hFFFF_FFFF_FFFF_FFFF;
        te[1] = {1'b1, 64'h0, 1'b1, 1'b1, 1'b0, 1'b0};
        ta[2] = 64'h7FFF_FFFF_FFFF_FFFF; tb_[2] = 64'h8000_0000_0000_0000;
        te[2] = {1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0};
        ta[3] = 64'hFFFF_FFFF_FFFF_FF80; tb_[3] = 64'd127;
        te[3] = {1'b1, 64'hFFFF_FFFF_FFFF_FF01, 1'b1, 1'b0, 1'b1, 1'b0};
        ta[4] = 64'h0;                  tb_[4] = 64'h0;
        te[4] = {1'b1, 64'h0, 1'b1, 1'b1, 1'b0, 1'b0};
        ta[5] = 64'h8000_0000_0000_0000; tb_[5] = 64'h7FFF_FFFF_FFFF_FFFF;
        te[5] = {1'b1, 64'h1, 1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 6; i++) begin
`ifdef COMPARATOR_UNSIGNED_EN
            te[i][0] = ulu[i];
`endif
            @(negedge clk);
            drive(1'b1, ta[i], tb_[i], te[i]);
            @(negedge clk);
            drive(1'b0, '0, '0, '0);
            e = q.pop_front();
            total++;
            if (obs !== e) $display("FAIL directed_%0d got=%h exp=%h", i, obs, e);
            else passed++;
            @(negedge clk);
            e = {1'b0, e[67:0]};
            total++;
            if (obs !== e) $display("FAIL hold_%0d got=%h exp=%h", i, obs, e);
            else passed++;
        end
    endtask

    task automatic test_exhaustive();
        logic [68:0] e;
        logic [63:0] a, b;
        int errs = 0;
        for (int i = -128; i < 128; i++) begin
            for (int j = -128; j < 128; j++) begin
                @(negedge clk);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    total++;
                    if (obs !== e) begin
                        errs++;
                        if (errs < 10) $display("FAIL exhaustive got=%h exp=%h", obs, e);
                    end else passed++;
                end
                a = 64'(signed'(i));
                b = 64'(signed'(j));
                drive(1'b1, a, b, model(a, b));
            end
        end
        @(negedge clk);
        drive(1'b0, '0, '0, '0);
        e = q.pop_front();
        total++;
        if (obs !== e) $display("FAIL exhaustive_last got=%h exp=%h", obs, e);
        else passed++;
    endtask

    task automatic test_reset_midstream();
        logic [68:0] e;
        logic [63:0] a, b;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            drive(1'b1, a, b, model(a, b));
        end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        e = '0;
        total++;
        if (obs !== e) $display("FAIL async_reset got=%h exp=%h", obs, e);
        else passed++;
        q.delete();
        @(posedge clk);
        #1;
        total++;
        if (obs !== e) $display("FAIL reset_held got=%h exp=%h", obs, e);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        a = 64'd3;
        b = 64'hFFFF_FFFF_FFFF_FFFE;
        drive(1'b1, a, b, model(a, b));
        @(negedge clk);
        drive(1'b0, '0, '0, '0);
        e = q.pop_front();
        total++;
        if (obs !== e) $display("FAIL after_reset got=%h exp=%h", obs, e);
        else passed++;
    endtask

    task automatic test_back_to_back_random();
        logic [68:0] e;
        logic [63:0] a, b;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (q.size() != 0) begin
                e = q.pop_front();
                total++;
                if (obs !== e) $display("FAIL random got=%h exp=%h", obs, e);
                else passed++;
            end
            a = {$urandom, $urandom};
            b = (k % 5 == 0) ? a : {$urandom, $urandom};
            drive(1'b1, a, b, model(a, b));
        end
        @(negedge clk);
        drive(1'b0, '0, '0, '0);
        e = q.pop_front();
        total++;
        if (obs !== e) $display("FAIL random_last got=%h exp=%h", obs, e);
        else passed++;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_directed();
        test_exhaustive();
        test_reset_midstream();
        test_back_to_back_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
